axi_mem_resp: RTL
=================

AXI_MEM_RESP -- requirements
Module: axi_mem_resp

Interface
REQ-001 SHALL have parameter MEM_LD, default 10, meaning log2 of the number of 512-bit memory words.
REQ-002 SHALL have parameter EN_WR, default 1, meaning write path (AW/W/B) present; when 0: awready=0, wready=0, bvalid=0.
REQ-003 SHALL have parameter EN_RD, default 1, meaning read path (AR/R) present; when 0: arready=0, rvalid=0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port axi_s, axi_bus_t.master modport, bundle: the responder side of the AXI bus (id 16, addr 64, len 8, size 3, data 512, strb 64, resp 2).

Function
REQ-007 SHALL map beat address to word index addr[6 +: MEM_LD]; the burst increments the index by 1 per beat and wraps modulo 2^MEM_LD.
REQ-008 SHALL flag a request as error when addr[63:6+MEM_LD] is nonzero or size != 3'd6.
REQ-009 SHALL run a write FSM with states W_IDLE, W_DATA, W_RESP; at most one write is outstanding.
REQ-010 SHALL drive awready=1 only in W_IDLE; on awvalid&&awready, latch awid, index, len and error flag, then go to W_DATA.
REQ-011 SHALL drive wready=1 only in W_DATA; each wvalid&&wready beat writes the bytes enabled by wstrb (no write when error), then advances the index.
REQ-012 SHALL count accepted beats and leave W_DATA on beat len+1 or on wlast, whichever comes first; extra beats are never accepted because wready deasserts.
REQ-013 SHALL in W_RESP assert bvalid with bid=latched awid, bresp=2'b10 on error else 2'b00, hold both stable until bready, and return to W_IDLE on bvalid&&bready.
REQ-014 SHALL run a read FSM with states R_IDLE, R_DATA; at most one read is outstanding.
REQ-015 SHALL drive arready=1 only in R_IDLE; on handshake, latch arid, index, len and error flag, then go to R_DATA.
REQ-016 SHALL present the first rvalid in the cycle after the AR handshake (1-cycle registered memory read latency).
REQ-017 SHALL hold rvalid, rid, rdata, rresp and rlast stable while rvalid&&!rready.
REQ-018 SHALL on each rvalid&&rready advance to the next beat with no bubble when rready stays high (one beat per cycle).
REQ-019 SHALL drive rid=latched arid, rresp=2'b10 and rdata=0 on error, else rresp=2'b00 and rdata=memory word; rlast=1 only on beat len+1.
REQ-020 SHALL return to R_IDLE on the rlast handshake; the next arready is asserted in the following cycle.
REQ-021 SHALL let the read and write paths operate concurrently; a read and write to the same word in the same cycle returns the pre-write data.
REQ-022 SHALL support len=0 (single beat) and len=255 (256 beats) identically to other lengths.

Reset
REQ-023 SHALL on rst_n=0, asynchronously and at any point mid-burst: return both FSMs to idle, clear beat counters, drive bvalid=0, rvalid=0, rlast=0, wready=0, bid=0, rid=0, bresp=0, rresp=0, rdata=0.
REQ-024 SHALL after reset release present awready=1 and arready=1 (when enabled); memory contents are not reset and an interrupted burst is not resumed or responded to.

Verification
REQ-025 SHALL cover: AW id=0x12 addr=0x40 len=3 size=6, 4 beats full strb data D0..D3 -> bvalid, bid=0x12, bresp=0; AR same -> 4 beats D0..D3, rid=0x12, rlast on beat 4, first rvalid 1 cycle after AR.
REQ-026 SHALL cover: write wstrb=0x0000_0000_0000_000F over prior all-0xFF word with data 0 -> readback has bytes 0..3 = 0x00, bytes 4..63 = 0xFF.
REQ-027 SHALL cover: addr=1<<(6+MEM_LD) write len=1 -> both beats accepted, bresp=2'b10, memory unchanged; read same -> 2 beats rdata=0, rresp=2'b10.
REQ-028 SHALL cover: read len=7 with rready toggled 1/0 each cycle -> 8 beats in order, outputs stable during stalls; burst starting at index 2^MEM_LD-2 wraps to index 0 on beat 3.
REQ-029 SHALL cover: rst_n pulsed low during beat 2 of a len=3 write and beat 2 of a len=3 read -> next cycle bvalid=0, rvalid=0, awready=1, arready=1; a following write/read completes normally.

Source files
------------

// File: rtl/axi_mem_resp_if.sv
// AXI bus bundle shared by the memory responder and whatever drives it.
// The master modport is the responder view: request channels in, response channels out.
interface axi_bus_t;
    logic [15:0]  awid;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic         awvalid;
    logic         awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [15:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [15:0]  arid;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic         arvalid;
    logic         arready;
    logic [15:0]  rid;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        input  awid, awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_mem_resp.sv
// AXI memory responder: 2^MEM_LD words of 512 bits, one outstanding write and one
// outstanding read, independent read/write paths, 1-cycle registered read latency.
module axi_mem_resp #(
    parameter int MEM_LD = 10,
    parameter bit EN_WR  = 1'b1,
    parameter bit EN_RD  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    axi_bus_t.master axi_s
);
    localparam int DEPTH = 1 << MEM_LD;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [511:0] mem [DEPTH];

    // Out-of-range address bits or any beat size other than 64 bytes is an error.
    function automatic logic req_err(input logic [63:0] addr, input logic [2:0] size);
        return ((addr >> (6 + MEM_LD)) != 64'd0) || (size != 3'd6);
    endfunction

    w_state_t          w_state, w_state_nxt;
    logic [15:0]       w_id;
    logic [MEM_LD-1:0] w_idx;
    logic [7:0]        w_len, w_cnt;
    logic              w_err;
    logic              aw_rdy, w_rdy, b_vld, aw_hs, w_hs;

    always_comb begin
        w_state_nxt = w_state;
        aw_rdy      = 1'b0;
        w_rdy       = 1'b0;
        b_vld       = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy = EN_WR;
                if (EN_WR && axi_s.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                w_rdy = 1'b1;
                if (axi_s.wvalid && (axi_s.wlast || w_cnt == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (axi_s.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = aw_rdy && axi_s.awvalid;
    assign w_hs  = w_rdy && axi_s.wvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_id  <= axi_s.awid;
                w_idx <= axi_s.awaddr[6 +: MEM_LD];
                w_len <= axi_s.awlen;
                w_cnt <= '0;
                w_err <= req_err(axi_s.awaddr, axi_s.awsize);
            end else if (w_hs) begin
                w_idx <= w_idx + MEM_LD'(1);
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < 64; b++) begin
                if (axi_s.wstrb[b]) mem[w_idx][b*8 +: 8] <= axi_s.wdata[b*8 +: 8];
            end
        end
    end

    assign axi_s.awready = aw_rdy;
    assign axi_s.wready  = w_rdy;
    assign axi_s.bvalid  = b_vld;
    assign axi_s.bid     = w_id;
    assign axi_s.bresp   = w_err ? 2'b10 : 2'b00;

    r_state_t          r_state, r_state_nxt;
    logic [15:0]       r_id;
    logic [MEM_LD-1:0] r_idx, rd_addr;
    logic [7:0]        r_len, r_cnt;
    logic              r_err, ar_err, rd_zero;
    logic              ar_rdy, r_vld, r_last, ar_hs, r_hs, rd_load;
    logic [511:0]      r_data;

    always_comb begin
        r_state_nxt = r_state;
        ar_rdy      = 1'b0;
        r_vld       = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = EN_RD;
                if (EN_RD && axi_s.arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (axi_s.rready && r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign r_last  = (r_state == R_DATA) && (r_cnt == r_len);
    assign ar_hs   = ar_rdy && axi_s.arvalid;
    assign r_hs    = r_vld && axi_s.rready;
    assign ar_err  = req_err(axi_s.araddr, axi_s.arsize);
    // Fetch the next word only on a handshake so rdata holds still through stalls.
    assign rd_load = ar_hs || (r_hs && !r_last);
    assign rd_addr = ar_hs ? axi_s.araddr[6 +: MEM_LD] : r_idx + MEM_LD'(1);
    assign rd_zero = ar_hs ? ar_err : r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id  <= axi_s.arid;
                r_idx <= axi_s.araddr[6 +: MEM_LD];
                r_len <= axi_s.arlen;
                r_cnt <= '0;
                r_err <= ar_err;
            end else if (r_hs) begin
                r_idx <= r_idx + MEM_LD'(1);
                r_cnt <= r_cnt + 8'd1;
            end
            if (rd_load) r_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

    assign axi_s.arready = ar_rdy;
    assign axi_s.rvalid  = r_vld;
    assign axi_s.rid     = r_id;
    assign axi_s.rdata   = r_data;
    assign axi_s.rresp   = r_err ? 2'b10 : 2'b00;
    assign axi_s.rlast   = r_last;
endmodule
